// File: rtl/store_buf_pkg.sv
// -----------------------------------------------------------------------------
// store_buf_pkg
// Shared types and constants for the posted store buffer.
//   sb_state_e   : controller state (IDLE / DRAIN / LOAD)
//   sb_payload_t : data-side part of a FIFO entry (store data + size/sign code).
//                  The address half of an entry has a parameterised width, so the
//                  FIFO keeps it in a parallel array next to the payload.
//   SB_DEPTH_MIN / SB_DEPTH_MAX, sb_depth_ok() : legal DEPTH range check.
// Optional feature macro used by the consumers of this package:
//   STORE_BUF_BYPASS_EN
// -----------------------------------------------------------------------------
package store_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } sb_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  sign_mask;
  } sb_payload_t;

  localparam int SB_DEPTH_MIN = 2;
  localparam int SB_DEPTH_MAX = 16;

  // DEPTH must be a power of two so the pointers wrap by plain overflow.
  function automatic bit sb_depth_ok(input int depth);
    return (depth >= SB_DEPTH_MIN) && (depth <= SB_DEPTH_MAX) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/store_buf_fifo.sv
// -----------------------------------------------------------------------------
// store_buf_fifo
// Storage for pending stores: circular buffer with read/write pointers, an
// occupancy count and a per-entry valid vector.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push                enqueue {push_addr, push_payload} (ignored when full)
//   pop                 drop the head entry (ignored when empty)
//   lookup_word         (STORE_BUF_BYPASS_EN only) word address to search for
//   lookup_hit          (STORE_BUF_BYPASS_EN only) a valid entry holds that word
//   head_addr/payload   oldest entry
//   full, empty         registered-count status
// Macro: STORE_BUF_BYPASS_EN builds one word-address comparator per entry;
// without it no comparators exist.
// -----------------------------------------------------------------------------
module store_buf_fifo
  import store_buf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  sb_payload_t       push_payload,
  input  logic              pop,
`ifdef STORE_BUF_BYPASS_EN
  input  logic [ADDR_W-3:0] lookup_word,
  output logic              lookup_hit,
`endif
  output logic [ADDR_W-1:0] head_addr,
  output sb_payload_t       head_payload,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  sb_payload_t       pay_mem  [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = ~|valid_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_addr    = addr_mem[rd_ptr];
  assign head_payload = pay_mem[rd_ptr];

  // Clear before set: a push and pop never target the same slot because
  // push is blocked when full and pop is blocked when empty.
  always_comb begin
    valid_d = valid_q;
    if (do_pop)  valid_d[rd_ptr] = 1'b0;
    if (do_push) valid_d[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      valid_q <= valid_d;
    end
  end

  // Entry storage carries no reset; the valid vector says what is live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      pay_mem[wr_ptr]  <= push_payload;
    end
  end

`ifdef STORE_BUF_BYPASS_EN
  logic [DEPTH-1:0] match_vec;

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid_q[i] && (addr_mem[i][ADDR_W-1:2] == lookup_word);
    end
  end

  assign lookup_hit = |match_vec;
`endif

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Posted store buffer between the CPU MEM stage and the data memory controller.
// Stores are queued and retired in the background; loads are ordered behind
// pending stores.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   addr, write_data, sign_mask      CPU request fields
//   memwrite, memread                CPU store / load request
//   read_data                        load result (valid when cpu_stall drops)
//   cpu_stall                        combinational stall back to the CPU
//   mem_addr, mem_write_data,
//   mem_sign_mask, mem_memwrite,
//   mem_memread                      registered request to data memory
//   mem_read_data, mem_done          response from data memory
// Macro: STORE_BUF_BYPASS_EN lets a load overtake pending stores whose word
// address differs from the load address.
//
// Handshakes: the CPU holds memwrite/memread and its request fields until it
// sees cpu_stall low; the request is consumed in that cycle. Toward memory,
// exactly one of mem_memwrite/mem_memread is held with stable fields until
// mem_done pulses, and drops the following cycle.
// -----------------------------------------------------------------------------
module store_buffer
  import store_buf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       write_data,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [3:0]        sign_mask,
  output logic [31:0]       read_data,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  output logic [3:0]        mem_sign_mask,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_done
);

  if (!sb_depth_ok(DEPTH)) begin : g_bad_depth
    $error("store_buffer: DEPTH must be a power of two between 2 and 16");
  end

  sb_state_e         state_q;
  sb_state_e         state_d;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              load_ack;
  logic              load_ok;
  logic              issue_load;
  logic              issue_drain;
  logic              load_done;
  logic [ADDR_W-1:0] head_addr;
  sb_payload_t       head_payload;
  sb_payload_t       push_payload;

  assign push_payload = '{data: write_data, sign_mask: sign_mask};

  // full comes from the registered count, so a pop in this cycle does not
  // release a stalled store until the next cycle.
  assign push      = memwrite & ~full;
  assign cpu_stall = (memwrite & full) | (memread & ~load_ack);

`ifdef STORE_BUF_BYPASS_EN
  logic bypass_hit;

  store_buf_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_addr    (addr),
    .push_payload (push_payload),
    .pop          (pop),
    .lookup_word  (addr[ADDR_W-1:2]),
    .lookup_hit   (bypass_hit),
    .head_addr    (head_addr),
    .head_payload (head_payload),
    .full         (full),
    .empty        (empty)
  );

  // A load may overtake pending stores only if none of them touches its word.
  assign load_ok = memread & ~load_ack & (empty | ~bypass_hit);
`else
  store_buf_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_addr    (addr),
    .push_payload (push_payload),
    .pop          (pop),
    .head_addr    (head_addr),
    .head_payload (head_payload),
    .full         (full),
    .empty        (empty)
  );

  assign load_ok = memread & ~load_ack & empty;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-cycle control strobes. Load wins over drain in IDLE.
  always_comb begin
    state_d     = state_q;
    issue_load  = 1'b0;
    issue_drain = 1'b0;
    pop         = 1'b0;
    load_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_ok) begin
          state_d    = ST_LOAD;
          issue_load = 1'b1;
        end else if (!empty) begin
          state_d     = ST_DRAIN;
          issue_drain = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (mem_done) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (mem_done) begin
          load_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered memory request and load result. Requests are loaded once at
  // issue and held untouched until the completion cycle clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_sign_mask  <= '0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      read_data      <= '0;
      load_ack       <= 1'b0;
    end else begin
      load_ack <= load_done;
      if (load_done) read_data <= mem_read_data;

      if (issue_load) begin
        mem_addr       <= addr;
        mem_write_data <= '0;
        mem_sign_mask  <= sign_mask;
        mem_memwrite   <= 1'b0;
        mem_memread    <= 1'b1;
      end else if (issue_drain) begin
        mem_addr       <= head_addr;
        mem_write_data <= head_payload.data;
        mem_sign_mask  <= head_payload.sign_mask;
        mem_memwrite   <= 1'b1;
        mem_memread    <= 1'b0;
      end else if (pop || load_done) begin
        mem_addr       <= '0;
        mem_write_data <= '0;
        mem_sign_mask  <= '0;
        mem_memwrite   <= 1'b0;
        mem_memread    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
// Directed bench for store_buffer (DEPTH=4, ADDR_W=32). A behavioural data
// memory answers each request after mem_lat falling edges; completed stores
// are checked in order against an expected queue filled by the CPU driver.
// Inputs change and outputs are sampled in the low phase of the clock.
// Honours STORE_BUF_BYPASS_EN for the load/store ordering expectation.
// -----------------------------------------------------------------------------
module tb_store_buffer;
  import store_buf_pkg::*;

  localparam int TIMEOUT = 200;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [3:0]  sign_mask = '0;
  logic [31:0] read_data;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_read_data = '0;
  logic        mem_done = 1'b0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .write_data     (write_data),
    .memwrite       (memwrite),
    .memread        (memread),
    .sign_mask      (sign_mask),
    .read_data      (read_data),
    .cpu_stall      (cpu_stall),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_sign_mask  (mem_sign_mask),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_read_data  (mem_read_data),
    .mem_done       (mem_done)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [67:0] got, input logic [67:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model + scoreboard ----------------
  logic [67:0] exp_q[$];     // {sign_mask, addr, data} of accepted stores
  logic [32:0] issue_q[$];   // {is_write, addr} in issue order
  logic [31:0] mem [int];
  int          mem_lat = 2;
  int          mem_cnt = 0;
  int          max_count = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int k;
    k = int'(a[11:2]);
    if (mem.exists(k)) return mem[k];
    return 32'hC000_0000 | 32'(k);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      mem_done = 1'b0;
      mem_cnt  = 0;
    end else if (mem_done) begin
      mem_done = 1'b0;
      mem_cnt  = 0;
    end else if (mem_memwrite || mem_memread) begin
      if (mem_cnt == 0) issue_q.push_back({mem_memwrite, mem_addr});
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        mem_done = 1'b1;
        if (mem_memwrite) begin
          check_eq("sb_pending", 68'(exp_q.size() != 0), 68'd1);
          if (exp_q.size() != 0)
            check_eq("mem_store", {mem_sign_mask, mem_addr, mem_write_data}, exp_q.pop_front());
          mem[int'(mem_addr[11:2])] = mem_write_data;
        end else begin
          mem_read_data = mem_rd(mem_addr);
        end
      end
    end
    if (int'(dut.u_fifo.count_q) > max_count) max_count = int'(dut.u_fifo.count_q);
  end

  // ---------------- driver tasks (called in the low phase) ----------------
  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           output int stalls);
    addr = a; write_data = d; sign_mask = m; memwrite = 1'b1; stalls = 0;
    #1;
    while (cpu_stall && stalls < TIMEOUT) begin
      @(negedge clk); #2;
      stalls++;
    end
    check_eq("store_accept", 68'(cpu_stall), 68'd0);
    exp_q.push_back({m, a, d});
    @(negedge clk); #1;
    memwrite = 1'b0;
  endtask

  task automatic cpu_load(input logic [31:0] a, input logic [3:0] m,
                          output logic [31:0] data, output int stalls);
    addr = a; sign_mask = m; memread = 1'b1; stalls = 0;
    #1;
    while (cpu_stall && stalls < TIMEOUT) begin
      @(negedge clk); #2;
      stalls++;
    end
    check_eq("load_accept", 68'(cpu_stall), 68'd0);
    data = read_data;
    @(negedge clk); #1;
    memread = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(dut.u_fifo.count_q == 0 && dut.state_q == ST_IDLE && !mem_memwrite &&
             !mem_memread) && n < TIMEOUT) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq(tag, 68'(n < TIMEOUT), 68'd1);
  endtask

  // ---------------- stimulus ----------------
  int          st;
  logic [31:0] rd;
  logic [32:0] first_exp;
  logic [32:0] second_exp;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_cpu_stall", 68'(cpu_stall), 68'd0);
    check_eq("rst_memwrite", 68'(mem_memwrite), 68'd0);
    check_eq("rst_memread", 68'(mem_memread), 68'd0);
    check_eq("rst_mem_addr", 68'(mem_addr), 68'd0);
    check_eq("rst_read_data", 68'(read_data), 68'd0);
    check_eq("rst_count", 68'(dut.u_fifo.count_q), 68'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Four posted stores: no stall, memory sees them in order
    mem_lat = 2;
    issue_q.delete();
    for (int i = 0; i < 4; i++) begin
      cpu_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'h2, st);
      check_eq("t2_stall", 68'(st), 68'd0);
    end
    wait_idle("t2_drain");
    check_eq("t2_issued", 68'(issue_q.size()), 68'd4);

    // Fifth store while full: stalls until the first pop
    mem_lat = 6;
    max_count = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_store(32'h110 + 32'(4 * i), 32'hB0 + 32'(i), 4'h1, st);
      check_eq("t3_stall", 68'(st), 68'd0);
    end
    cpu_store(32'h120, 32'hB4, 4'h1, st);
    check_eq("t3_full_stall", 68'(st), 68'd4);
    wait_idle("t3_drain");
    check_eq("t3_max_count", 68'(max_count), 68'd4);
    mem_lat = 2;

    // Load from an empty buffer: request at t+1, data the cycle after done
    issue_q.delete();
    cpu_load(32'h408, 4'h2, rd, st);
    check_eq("t4a_stalls", 68'(st), 68'd3);
    check_eq("t4a_data", 68'(rd), 68'hC000_0102);
    check_eq("t4a_issue", 68'(issue_q[0]), {35'd0, 1'b0, 32'h408});

    // Store then load to the same word: drain first, load sees new data
    issue_q.delete();
    cpu_store(32'h200, 32'h55, 4'h2, st);
    cpu_load(32'h200, 4'h2, rd, st);
    check_eq("t4_data", 68'(rd), 68'h55);
    check_eq("t4_first", 68'(issue_q[0]), {35'd0, 1'b1, 32'h200});
    check_eq("t4_second", 68'(issue_q[1]), {35'd0, 1'b0, 32'h200});
    wait_idle("t4_idle");

    // Pending store 0x300, load 0x400: order depends on the bypass build
    issue_q.delete();
    cpu_store(32'h300, 32'h66, 4'h3, st);
    cpu_load(32'h400, 4'h2, rd, st);
    check_eq("t5_data", 68'(rd), 68'hC000_0100);
    wait_idle("t5_idle");
`ifdef STORE_BUF_BYPASS_EN
    first_exp  = {1'b0, 32'h400};
    second_exp = {1'b1, 32'h300};
`else
    first_exp  = {1'b1, 32'h300};
    second_exp = {1'b0, 32'h400};
`endif
    check_eq("t5_first", 68'(issue_q[0]), 68'(first_exp));
    check_eq("t5_second", 68'(issue_q[1]), 68'(second_exp));

    // Reset in the middle of a load
    mem_lat = 8;
    addr = 32'h404; sign_mask = 4'h6; memread = 1'b1;
    st = 0;
    while (!mem_memread && st < TIMEOUT) begin
      @(negedge clk); #1;
      st++;
    end
    check_eq("t6_req_seen", 68'(mem_memread), 68'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_memread", 68'(mem_memread), 68'd0);
    check_eq("t6_memwrite", 68'(mem_memwrite), 68'd0);
    check_eq("t6_mem_addr", 68'(mem_addr), 68'd0);
    check_eq("t6_mem_mask", 68'(mem_sign_mask), 68'd0);
    check_eq("t6_read_data", 68'(read_data), 68'd0);
    check_eq("t6_count", 68'(dut.u_fifo.count_q), 68'd0);
    check_eq("t6_state", 68'(dut.state_q), 68'(ST_IDLE));
    check_eq("t6_stall_rd", 68'(cpu_stall), 68'd1);
    memread = 1'b0;
    #1;
    check_eq("t6_stall_none", 68'(cpu_stall), 68'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    mem_lat = 2;
    @(negedge clk); #1;

    // Enqueue and pop in the same cycle at count 2, across pointer wrap
    cpu_store(32'h500, 32'hD0, 4'h4, st);
    cpu_store(32'h504, 32'hD1, 4'h4, st);
    st = 0;
    for (int i = 0; i < 10; i++) begin
      check_eq("t7_count", 68'(dut.u_fifo.count_q), 68'd2);
      if (mem_done) begin
        addr = 32'h508 + 32'(4 * st); write_data = 32'hD2 + 32'(st); sign_mask = 4'h4;
        memwrite = 1'b1;
        exp_q.push_back({4'h4, addr, write_data});
        st++;
      end else begin
        memwrite = 1'b0;
      end
      @(negedge clk); #1;
    end
    memwrite = 1'b0;
    check_eq("t7_pushes", 68'(st), 68'd3);
    check_eq("t7_wr_ptr", 68'(dut.u_fifo.wr_ptr), 68'd1);
    check_eq("t7_rd_ptr", 68'(dut.u_fifo.rd_ptr), 68'd3);
    wait_idle("t7_drain");

    check_eq("sb_empty_end", 68'(exp_q.size()), 68'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted store buffer between the CPU MEM stage and the data memory controller. Stores are queued in a small FIFO and retired to data memory in the background, so a store normally costs zero stall cycles. Loads are serialised against pending stores to keep memory ordering correct. The block sits directly upstream of the data memory and presents the same address/data/sign_mask request format to it.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- ADDR_W, 32, address width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- addr  in  ADDR_W  CPU byte address
- write_data  in  32  CPU store data
- memwrite  in  1  CPU store request, held until cpu_stall low
- memread  in  1  CPU load request, held until cpu_stall low
- sign_mask  in  4  size/sign code, passed through unchanged
- read_data  out  32  load result, valid in cycle cpu_stall drops for a load
- cpu_stall  out  1  combinational; CPU holds request while high
- mem_addr  out  ADDR_W  request address to data memory
- mem_write_data  out  32  store data to data memory
- mem_sign_mask  out  4  size/sign code to data memory
- mem_memwrite  out  1  store request, held until mem_done
- mem_memread  out  1  load request, held until mem_done
- mem_read_data  in  32  load data, valid with mem_done
- mem_done  in  1  one-cycle completion pulse from data memory

## Operation
- FIFO entry = {addr, write_data, sign_mask}; count 0..DEPTH; full = (count==DEPTH).
- Store: enqueue on rising edge when memwrite & ~full. cpu_stall = memwrite & full. A dequeue in the same cycle does not unblock a full FIFO; stall decision uses registered count.
- States: IDLE, DRAIN (store in flight), LOAD (load in flight).
- IDLE: if load eligible -> LOAD, drive mem_memread with CPU addr/sign_mask. Else if count>0 -> DRAIN, drive head entry with mem_memwrite. Load has priority over drain when eligible.
- Load eligible: memread & ~load_ack & (count==0), or as extended by the configured bypass.
- DRAIN: on mem_done pop head, -> IDLE. LOAD: on mem_done capture mem_read_data into read_data, set load_ack, -> IDLE.
- load_ack is high exactly one cycle. cpu_stall for loads = memread & ~load_ack.
- Simultaneous enqueue and dequeue: count unchanged, pointers both advance.
- Pointers wrap modulo DEPTH.
- Reset, including mid-transaction: FIFO empty, state IDLE, in-flight access abandoned.
- Reset values: read_data=0, load_ack=0, and all mem_* outputs 0.
- cpu_stall=0 during reset unless memread/memwrite are asserted.

## Timing
- Store with FIFO not full: 0 stall cycles.
- Load, FIFO empty, IDLE at cycle t: mem_memread registered high at t+1.
- Load completion: mem_done at cycle d; read_data valid and cpu_stall low at d+1.
- mem_* outputs are registered, stable for the whole transaction, and drop the cycle after mem_done.
- One memory transaction outstanding at a time. Back-to-back drains have one IDLE cycle between them.

## Configuration
- STORE_BUF_BYPASS_EN defined: a load is also eligible when count>0 and no valid entry matches addr[ADDR_W-1:2]. Such a load is issued ahead of pending stores. A matching entry forces drain-before-load.
- Not defined: loads always wait for count==0. No address comparators are built.

## Structure
- Package store_buf_pkg:
  - state enum (IDLE/DRAIN/LOAD)
  - entry struct type
  - DEPTH bounds check constants
- Sub-module store_buf_fifo:
  - storage, pointers, count, full/empty
  - per-entry valid vector, used by the bypass comparators

## Test plan
- Four stores 0x100..0x10C with data 0xA0..0xA3, mem_done 2 cycles after each request -> zero CPU stall. Memory sees the stores in order with data 0xA0..0xA3.
- Fifth store while full -> cpu_stall high until first mem_done, then accepted next cycle; count never exceeds 4.
- Store 0x200=0x55 then load 0x200 -> the load waits for the drain, and read_data=0x55 (both configurations).
- With STORE_BUF_BYPASS_EN: pending store 0x300, then load 0x400 -> mem_memread for 0x400 is issued before mem_memwrite for 0x300. Without the macro the order is reversed.
- Assert rst during LOAD while mem_memread=1 -> all mem_* outputs 0 immediately, count=0, read_data=0.
- Simultaneous store enqueue and drain pop at count=2 -> count stays 2, pointers wrap correctly over 10 cycles.
